rede_out_fifo: RTL
==================

REDE_OUT_FIFO -- requirements
Module: rede_out_fifo

Interface
REQ-001 Parameter NBITS, default 28, width of the integer result word from the float-to-int output stage.
REQ-002 Parameter NPORT, default 4, number of processor output ports (width of out_en).
REQ-003 Parameter DEPTH, default 8, FIFO entries; power of two, minimum 2.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 io_out  input  NBITS  signed result word from the float-to-int stage.
REQ-007 out_en  input  NPORT  one-hot port strobe from the output address decoder; all-zero means idle.
REQ-008 m_data  output  NBITS  head-entry data word.
REQ-009 m_port  output  log2(NPORT)  head-entry port index.
REQ-010 m_valid  output  1  head entry present.
REQ-011 m_ready  input  1  consumer accepts head entry.
REQ-012 count  output  log2(DEPTH)+1  current occupancy.
REQ-013 full  output  1  count equals DEPTH.
REQ-014 overflow  output  1  sticky: a capture was dropped.
REQ-015 onehot_err  output  1  sticky: out_en had more than one bit set.
REQ-016 clr  input  1  clears overflow, onehot_err and drop_cnt; does not touch FIFO contents.
REQ-017 drop_cnt  output  8  dropped-capture count (see Configuration).

Function
REQ-018 Push condition: out_en nonzero on a rising edge; entry = {io_out, encoded port index}.
REQ-019 Port encoding: index of lowest set bit of out_en; more than one bit set also sets onehot_err.
REQ-020 Pop condition: m_valid and m_ready on the same rising edge; head pointer advances by one.
REQ-021 m_valid = (count != 0); m_data/m_port come from a registered head entry, stable while m_valid and not m_ready.
REQ-022 Latency: a push at edge N into an empty FIFO gives m_valid=1 and the data after edge N, i.e. visible in cycle N+1; no combinational path from io_out/out_en to outputs.
REQ-023 Pointers: write/read pointers of log2(DEPTH) bits; they wrap modulo DEPTH without any gap.
REQ-024 Empty with push and m_ready=1: push only; count becomes 1.
REQ-025 Full with push and pop on the same edge: both succeed; count stays DEPTH; no overflow.
REQ-026 Full with push and no pop: capture dropped; FIFO unchanged; overflow set; drop_cnt increments.
REQ-027 Non-full with push and pop on the same edge: both succeed; count unchanged.
REQ-028 Sticky flags hold until clr or rst; if clr and a new error condition occur on the same edge, the flag ends set.
REQ-029 full = (count == DEPTH), derived from the registered count.

Reset
REQ-030 When rst=1 at a rising edge: pointers=0, count=0, m_valid=0, full=0, overflow=0, onehot_err=0, drop_cnt=0.
REQ-031 m_data and m_port read 0 after reset until the first push.
REQ-032 rst overrides push, pop and clr on the same edge; reset mid-stream discards all stored entries.

Configuration
REQ-033 Macro REDE_OUT_FIFO_DROPCNT_EN.
REQ-034 With the macro defined: drop_cnt is an 8-bit counter that saturates at 255, increments once per dropped capture and is cleared by clr or rst.
REQ-035 With the macro undefined: drop_cnt is tied to 0 and no counter logic is built; overflow behaviour is unchanged.

Verification
REQ-036 Write 3 then pop 3: out_en=0001 with io_out=100, out_en=0100 with -5, out_en=1000 with 7; m_ready=1 afterward -> reads (100,0), (-5,2), (7,3) in order; count returns to 0.
REQ-037 Full drop: 8 pushes with m_ready=0, then a 9th push of 999 -> full=1, overflow=1, drop_cnt=1 (macro on) or 0 (macro off); pops return the first 8 values only.
REQ-038 Full simultaneous: FIFO full, push 42 with m_ready=1 -> count stays 8, overflow=0, and 42 is read last.
REQ-039 Wrap-around: 20 pushes, each popped the next cycle, with io_out=i -> values 0..19 read in order; count never exceeds 2.
REQ-040 Multi-hot: out_en=0110 with io_out=11 -> entry (11,1) and onehot_err=1; clr pulse -> onehot_err=0.
REQ-041 Reset mid-stream: 5 entries stored, rst held 1 cycle together with a push -> count=0, m_valid=0, and all flags 0 next cycle.

Source files
------------

// File: rtl/rede_out_fifo_if.sv
// Output-port bus for rede_out_fifo: capture side (io_out/out_en) and the
// drain side (m_data/m_port/m_valid/m_ready). master = FIFO, slave = environment.
interface rede_out_fifo_if #(
  parameter int NBITS = 28,
  parameter int NPORT = 4
);
  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

  // Drain handshake: an entry moves on every rising edge where m_valid and
  // m_ready are both high; m_data/m_port hold while m_valid && !m_ready.
  // Capture side has no backpressure: out_en != 0 is a push request on that edge.
  logic [NBITS-1:0] io_out;
  logic [NPORT-1:0] out_en;
  logic [NBITS-1:0] m_data;
  logic [PW-1:0]    m_port;
  logic             m_valid;
  logic             m_ready;

  modport master (input io_out, out_en, m_ready, output m_data, m_port, m_valid);
  modport slave  (output io_out, out_en, m_ready, input m_data, m_port, m_valid);
endinterface

// File: rtl/rede_out_fifo.sv
// Processor output FIFO: captures {io_out, port index} on each out_en strobe.
// Optional saturating drop counter enabled by macro REDE_OUT_FIFO_DROPCNT_EN.
module rede_out_fifo #(
  parameter int NBITS = 28,
  parameter int NPORT = 4,
  parameter int DEPTH = 8,
  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1,
  localparam int AW = $clog2(DEPTH),
  localparam int EW = NBITS + PW
) (
  input  logic            clk,
  input  logic            rst,
  rede_out_fifo_if.master bus,
  input  logic            clr,
  output logic [AW:0]     count,
  output logic            full,
  output logic            overflow,
  output logic            onehot_err,
  output logic [7:0]      drop_cnt
);

  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [EW-1:0]    mem [DEPTH];
  logic [EW-1:0]    head;
  logic [EW-1:0]    head_d;
  logic [EW-1:0]    new_entry;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_next;
  logic [AW:0]      count_d;
  logic [PW-1:0]    enc_port;
  logic             push_req;
  logic             push_ok;
  logic             pop;
  logic             drop;
  logic             multi_hot;

  // Lowest set bit wins when the decoder strobes more than one port.
  always_comb begin
    enc_port = '0;
    for (int i = NPORT - 1; i >= 0; i--) begin
      if (bus.out_en[i]) enc_port = PW'(i);
    end
  end

  assign push_req  = |bus.out_en;
  assign multi_hot = (bus.out_en & (bus.out_en - NPORT'(1))) != '0;
  assign pop       = (count != '0) && bus.m_ready;
  assign push_ok   = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;
  assign new_entry = {bus.io_out, enc_port};
  assign rd_next   = pop ? rd_ptr + PTR_ONE : rd_ptr;

  always_comb begin
    count_d = count;
    case ({push_ok, pop})
      2'b10:   count_d = count + CNT_ONE;
      2'b01:   count_d = count - CNT_ONE;
      default: count_d = count;
    endcase
  end

  // wr_ptr == rd_next with an accepted push means the FIFO is empty after
  // this edge's pop, so the incoming entry goes straight to the head register.
  always_comb begin
    head_d = head;
    if (push_ok && (wr_ptr == rd_next)) head_d = new_entry;
    else if (pop)                       head_d = mem[rd_next];
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wr_ptr] <= new_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head       <= '0;
      overflow   <= 1'b0;
      onehot_err <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      rd_ptr     <= rd_next;
      count      <= count_d;
      head       <= head_d;
      overflow   <= (overflow && !clr) || drop;
      onehot_err <= (onehot_err && !clr) || multi_hot;
    end
  end

`ifdef REDE_OUT_FIFO_DROPCNT_EN
  // A drop on the same edge as clr still counts, mirroring the sticky flags.
  always_ff @(posedge clk) begin
    if (rst)                          drop_cnt <= 8'd0;
    else if (clr)                     drop_cnt <= drop ? 8'd1 : 8'd0;
    else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end
`else
  assign drop_cnt = 8'd0;
`endif

  assign full        = (count == CNT_MAX);
  assign bus.m_valid = (count != '0);
  assign bus.m_data  = head[EW-1:PW];
  assign bus.m_port  = head[PW-1:0];

endmodule
